// File: rtl/lvds_rx_align_ctrl_if.sv
// Control/status bundle between an LVDS deserializer and its word-alignment controller.
// The master side drives lock, frame word and restart; the slave side is the controller.
interface lvds_rx_align_ctrl_if #(
    parameter int unsigned SER_FACTOR = 6
);
    logic                  rx_locked;
    logic [SER_FACTOR-1:0] fclk_word;
    logic                  start;
    logic                  rx_data_align;
    logic                  aligned;
    logic                  align_err;
    logic [3:0]            slip_count;
    logic [15:0]           err_count;

    modport master (
        output rx_locked, fclk_word, start,
        input  rx_data_align, aligned, align_err, slip_count, err_count
    );

    modport slave (
        input  rx_locked, fclk_word, start,
        output rx_data_align, aligned, align_err, slip_count, err_count
    );
endinterface

// File: rtl/lvds_rx_align_ctrl.sv
// Frame-clock word aligner: bitslips the deserializer until fclk_word matches the
// expected pattern, then supervises the lock and re-aligns when it is lost.
module lvds_rx_align_ctrl #(
    parameter int unsigned           SER_FACTOR    = 6,
    parameter logic [SER_FACTOR-1:0] FCLK_PATTERN  = 6'b111000,
    parameter int unsigned           SETTLE_CYCLES = 4,
    parameter int unsigned           ALIGN_PULSE   = 2,
    parameter int unsigned           MATCH_COUNT   = 16,
    parameter int unsigned           MAX_SLIPS     = 12,
    parameter int unsigned           MISS_LIMIT    = 4
) (
    input logic                 rx_clk,
    input logic                 reset,
    lvds_rx_align_ctrl_if.slave bus
);

    localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);
    localparam logic [1:0] PULSE_N  = 2'(ALIGN_PULSE);
    localparam logic [7:0] MATCH_N  = 8'(MATCH_COUNT);
    localparam logic [3:0] SLIPS_N  = 4'(MAX_SLIPS);
    localparam logic [3:0] MISS_N   = 4'(MISS_LIMIT);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        lock_s_q;
    logic [3:0]  settle_cnt_q;
    logic [1:0]  pulse_cnt_q;
    logic [7:0]  match_cnt_q;
    logic [3:0]  miss_cnt_q;
    logic [3:0]  slip_count_q;
    logic [15:0] err_count_q;
    logic        aligned_q;
    logic        align_err_q;
    logic        rx_data_align_q;

    logic        match;
    logic [7:0]  match_cnt_d;
    logic [3:0]  miss_cnt_d;
    logic [15:0] err_count_d;

    always_comb begin
        match       = (bus.fclk_word == FCLK_PATTERN);
        match_cnt_d = match_cnt_q + 8'd1;
        miss_cnt_d  = miss_cnt_q + 4'd1;
        err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 16'd1;
    end

    // rx_locked comes straight from the deserializer PLL, unrelated to rx_clk.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= bus.rx_locked;
            lock_s_q <= sync1_q;
        end
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state_q         <= WAIT_LOCK;
            settle_cnt_q    <= '0;
            pulse_cnt_q     <= '0;
            match_cnt_q     <= '0;
            miss_cnt_q      <= '0;
            slip_count_q    <= '0;
            err_count_q     <= '0;
            aligned_q       <= 1'b0;
            align_err_q     <= 1'b0;
            rx_data_align_q <= 1'b0;
        end else if (bus.start) begin
            state_q         <= WAIT_LOCK;
            settle_cnt_q    <= '0;
            pulse_cnt_q     <= '0;
            match_cnt_q     <= '0;
            miss_cnt_q      <= '0;
            slip_count_q    <= '0;
            err_count_q     <= '0;
            aligned_q       <= 1'b0;
            align_err_q     <= 1'b0;
            rx_data_align_q <= 1'b0;
        end else if (!lock_s_q && state_q != WAIT_LOCK) begin
            // Lock loss truncates any slip pulse; error history survives.
            state_q         <= WAIT_LOCK;
            settle_cnt_q    <= '0;
            pulse_cnt_q     <= '0;
            match_cnt_q     <= '0;
            miss_cnt_q      <= '0;
            slip_count_q    <= '0;
            aligned_q       <= 1'b0;
            rx_data_align_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s_q) begin
                        settle_cnt_q <= SETTLE_N;
                        state_q      <= SETTLE;
                    end
                end

                SETTLE: begin
                    rx_data_align_q <= 1'b0;
                    settle_cnt_q    <= settle_cnt_q - 4'd1;
                    if (settle_cnt_q <= 4'd1) begin
                        match_cnt_q <= '0;
                        state_q     <= CHECK;
                    end
                end

                CHECK: begin
                    if (match) begin
                        match_cnt_q <= match_cnt_d;
                        if (match_cnt_d == MATCH_N) begin
                            miss_cnt_q <= '0;
                            aligned_q  <= 1'b1;
                            state_q    <= LOCKED;
                        end
                    end else if (slip_count_q < SLIPS_N) begin
                        slip_count_q    <= slip_count_q + 4'd1;
                        pulse_cnt_q     <= PULSE_N;
                        rx_data_align_q <= 1'b1;
                        state_q         <= SLIP;
                    end else begin
                        align_err_q <= 1'b1;
                        state_q     <= FAIL;
                    end
                end

                SLIP: begin
                    if (pulse_cnt_q <= 2'd1) begin
                        rx_data_align_q <= 1'b0;
                        settle_cnt_q    <= SETTLE_N;
                        state_q         <= SETTLE;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - 2'd1;
                    end
                end

                LOCKED: begin
                    if (match) begin
                        miss_cnt_q <= '0;
                    end else begin
                        err_count_q <= err_count_d;
                        if (miss_cnt_d == MISS_N) begin
                            // Re-acquire from CHECK without slipping first.
                            miss_cnt_q   <= '0;
                            match_cnt_q  <= '0;
                            slip_count_q <= '0;
                            aligned_q    <= 1'b0;
                            state_q      <= CHECK;
                        end else begin
                            miss_cnt_q <= miss_cnt_d;
                        end
                    end
                end

                FAIL: begin
                    align_err_q <= 1'b1;
                end

                default: begin
                    state_q <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign bus.rx_data_align = rx_data_align_q;
    assign bus.aligned       = aligned_q;
    assign bus.align_err     = align_err_q;
    assign bus.slip_count    = slip_count_q;
    assign bus.err_count     = err_count_q;

endmodule

// File: tb/tb_lvds_rx_align_ctrl.sv
// Bench for lvds_rx_align_ctrl: a rotating-deserializer model plus timing expectations
// derived from the slip/settle/match cycle arithmetic.
module tb_lvds_rx_align_ctrl;

    localparam logic [5:0] PATTERN     = 6'b111000;
    localparam int         SETTLE      = 4;
    localparam int         PULSE       = 2;
    localparam int         MATCHN      = 16;
    localparam int         MAXS        = 12;
    localparam int         MISSN       = 4;
    // rx_locked high -> aligned: 2 sync + exit + settle + matches
    localparam int         LOCK_LAT    = 2 + SETTLE + 1 + MATCHN;
    localparam int         SLIP_PERIOD = PULSE + SETTLE + 1;

    logic rx_clk = 1'b0;
    logic reset;
    always #5 rx_clk = ~rx_clk;

    lvds_rx_align_ctrl_if #(.SER_FACTOR(6)) bus ();

    lvds_rx_align_ctrl #(
        .SER_FACTOR   (6),
        .FCLK_PATTERN (PATTERN),
        .SETTLE_CYCLES(SETTLE),
        .ALIGN_PULSE  (PULSE),
        .MATCH_COUNT  (MATCHN),
        .MAX_SLIPS    (MAXS),
        .MISS_LIMIT   (MISSN)
    ) dut (
        .rx_clk(rx_clk),
        .reset (reset),
        .bus   (bus)
    );

    int         tests;
    int         failed;
    int         off;
    bit         mode;
    logic [5:0] force_word;
    bit         prev_al;
    int         exp_err;
    int         seq[64];
    int         seq_len;

    typedef struct {
        int off;
        bit zero;
        int exp_slips;
        int exp_cycle;
        bit exp_fail;
    } acq_vec_t;

    acq_vec_t vecs[5];

    function automatic logic [5:0] rotl(input logic [5:0] w, input int n);
        logic [5:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[4:0], r[5]};
        return r;
    endfunction

    task automatic apply_word();
        bus.fclk_word = mode ? force_word : rotl(PATTERN, off);
    endtask

    task automatic tick();
        @(posedge rx_clk);
        @(negedge rx_clk);
        if (bus.rx_data_align && !prev_al) off = (off + 1) % 6;
        prev_al = bus.rx_data_align;
        apply_word();
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_rx_data_align"}, int'(bus.rx_data_align), 0);
        check({name, "_aligned"},       int'(bus.aligned),       0);
        check({name, "_align_err"},     int'(bus.align_err),     0);
        check({name, "_slip_count"},    int'(bus.slip_count),    0);
        check({name, "_err_count"},     int'(bus.err_count),     0);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.rx_locked = 1'b0;
        bus.start     = 1'b0;
        tick();
        reset   = 1'b0;
        exp_err = 0;
    endtask

    task automatic run_acq(input string name, input int exp_slips, input int exp_cycle,
                           input bit exp_fail, input bit with_reset);
        int pulses;
        int last_rise;
        int width;
        int bad_w;
        int bad_sp;
        int ev;
        bit hi;
        pulses = 0; last_rise = -1; width = 0; bad_w = 0; bad_sp = 0; ev = -1; hi = 0;
        if (with_reset) do_reset();
        bus.rx_locked = 1'b1;
        for (int cyc = 1; cyc <= 200 && ev < 0; cyc++) begin
            tick();
            if (bus.rx_data_align) begin
                if (!hi) begin
                    pulses++;
                    check({name, "_slip_at_pulse"}, int'(bus.slip_count), pulses);
                    if (last_rise >= 0 && cyc - last_rise != SLIP_PERIOD) bad_sp++;
                    last_rise = cyc;
                    width = 0;
                end
                width++;
                hi = 1;
            end else begin
                if (hi && width != PULSE) bad_w++;
                hi = 0;
            end
            if (bus.aligned || bus.align_err) ev = cyc;
        end
        if (ev < 0) begin
            tests++;
            failed++;
            $display("FAIL %s_timeout: got no aligned/align_err, expected one by cycle %0d",
                     name, exp_cycle);
        end else begin
            check({name, "_event_cycle"}, ev, exp_cycle);
        end
        check({name, "_pulses"},     pulses, exp_slips);
        check({name, "_slip_count"}, int'(bus.slip_count), exp_slips);
        check({name, "_aligned"},    int'(bus.aligned),     int'(!exp_fail));
        check({name, "_align_err"},  int'(bus.align_err),   int'(exp_fail));
        check({name, "_pulse_width"}, bad_w, 0);
        check({name, "_pulse_space"}, bad_sp, 0);
    endtask

    // Drives seq[] (1 = miss) while LOCKED, then restores the pattern and expects re-lock.
    task automatic locked_seq(input string name);
        int run;
        bit dropped;
        run = 0;
        dropped = 0;
        for (int i = 0; i < seq_len && !dropped; i++) begin
            mode = 1;
            force_word = (seq[i] != 0) ? 6'b000000 : PATTERN;
            apply_word();
            tick();
            if (seq[i] != 0) begin
                if (exp_err < 65535) exp_err++;
                run++;
            end else begin
                run = 0;
            end
            if (run >= MISSN) dropped = 1;
            check({name, "_aligned"}, int'(bus.aligned), int'(!dropped));
            check({name, "_err"},     int'(bus.err_count), exp_err);
        end
        check({name, "_dropped"},    int'(dropped), 1);
        check({name, "_slip_clear"}, int'(bus.slip_count), 0);
        mode = 0;
        apply_word();
        for (int k = 1; k <= MATCHN; k++) begin
            tick();
            check({name, "_realign"}, int'(bus.aligned), int'(k == MATCHN));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end before 1ms");
        $fatal(1);
    end

    initial begin
        int n;
        int run;
        int guard;
        int stray;
        bit seen_hi;
        bit b;

        tests = 0; failed = 0; off = 0; mode = 0; force_word = '0; prev_al = 0;
        exp_err = 0; seq_len = 0;
        reset = 1'b1;
        bus.rx_locked = 1'b0;
        bus.start = 1'b0;
        bus.fclk_word = '0;
        repeat (2) @(posedge rx_clk);
        @(negedge rx_clk);
        check_zero("reset_state");
        reset = 1'b0;

        vecs[0] = '{0, 0, 0,  LOCK_LAT,      0};
        vecs[1] = '{3, 0, 3,  44,            0};
        vecs[2] = '{1, 0, 5,  58,            0};
        vecs[3] = '{5, 0, 1,  30,            0};
        vecs[4] = '{0, 1, 12, 92,            1};

        for (int i = 0; i < 5; i++) begin
            off = vecs[i].off;
            mode = vecs[i].zero;
            force_word = '0;
            apply_word();
            run_acq($sformatf("vec%0d", i), vecs[i].exp_slips, vecs[i].exp_cycle,
                    vecs[i].exp_fail, 1);
        end

        // Held in FAIL until start.
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.align_err || bus.rx_data_align || bus.aligned) stray++;
        end
        check("fail_hold", stray, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_err = 0;
        check("start_clr_align_err",  int'(bus.align_err),  0);
        check("start_clr_slip_count", int'(bus.slip_count), 0);

        // LOCKED: 3 misses, 1 match, 4 misses.
        off = 3; mode = 0; apply_word();
        run_acq("lock3", 3, 44, 0, 1);
        seq_len = 8;
        seq[0] = 1; seq[1] = 1; seq[2] = 1; seq[3] = 0;
        seq[4] = 1; seq[5] = 1; seq[6] = 1; seq[7] = 1;
        locked_seq("det");
        check("det_err7", int'(bus.err_count), 7);

        // Random miss pattern; err_count carries over from the previous drop.
        seq_len = 0; run = 0;
        while (seq_len < 40 && run < MISSN) begin
            b = ($urandom_range(0, 9) < 4);
            seq[seq_len] = int'(b);
            seq_len++;
            run = b ? run + 1 : 0;
        end
        while (run < MISSN) begin
            seq[seq_len] = 1;
            seq_len++;
            run++;
        end
        locked_seq("rnd_keep");

        // Reset while LOCKED with nonzero err_count.
        reset = 1'b1;
        #1;
        check_zero("reset_locked");
        tick();
        reset = 1'b0;
        exp_err = 0;

        // Reset mid-SETTLE after the first slip.
        do_reset();
        off = 3; mode = 0; apply_word();
        bus.rx_locked = 1'b1;
        seen_hi = 0; guard = 0;
        while (guard < 60 && !(seen_hi && !bus.rx_data_align)) begin
            tick();
            if (bus.rx_data_align) seen_hi = 1;
            guard++;
        end
        check("settle_reached", int'(seen_hi && !bus.rx_data_align), 1);
        tick();
        reset = 1'b1;
        #1;
        check_zero("reset_settle");
        tick();
        check_zero("reset_settle_held");
        reset = 1'b0;
        exp_err = 0;
        n = (6 - off) % 6;
        run_acq("after_reset", n, LOCK_LAT + n * SLIP_PERIOD, 0, 0);

        // Reset and start on the same cycle.
        bus.start = 1'b1;
        reset = 1'b1;
        #1;
        check_zero("reset_start");
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        exp_err = 0;
        n = (6 - off) % 6;
        run_acq("after_reset_start", n, LOCK_LAT + n * SLIP_PERIOD, 0, 0);

        // Lock loss during SLIP.
        do_reset();
        off = 3; mode = 0; apply_word();
        bus.rx_locked = 1'b1;
        guard = 0;
        while (guard < 60 && !bus.rx_data_align) begin
            tick();
            guard++;
        end
        check("slip_reached", int'(bus.rx_data_align), 1);
        bus.rx_locked = 1'b0;
        repeat (3) tick();
        check("lockloss_rx_data_align", int'(bus.rx_data_align), 0);
        check("lockloss_slip_count",    int'(bus.slip_count),    0);
        check("lockloss_aligned",       int'(bus.aligned),       0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rx_data_align || bus.slip_count != 0) stray++;
        end
        check("lockloss_idle", stray, 0);
        n = (6 - off) % 6;
        run_acq("relock", n, LOCK_LAT + n * SLIP_PERIOD, 0, 0);

        // Randomized starting offsets and LOCKED miss patterns.
        for (int r = 0; r < 8; r++) begin
            off = $urandom_range(0, 5);
            mode = 0;
            apply_word();
            n = (6 - off) % 6;
            run_acq($sformatf("rnd%0d", r), n, LOCK_LAT + n * SLIP_PERIOD, 0, 1);
            seq_len = 0; run = 0;
            while (seq_len < 40 && run < MISSN) begin
                b = ($urandom_range(0, 9) < 4);
                seq[seq_len] = int'(b);
                seq_len++;
                run = b ? run + 1 : 0;
            end
            while (run < MISSN) begin
                seq[seq_len] = 1;
                seq_len++;
                run++;
            end
            locked_seq($sformatf("rnd%0d_locked", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
